// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int CNT_W = 3;

  // Branch resolution: JC with NEQ=0 takes on zero, with NEQ=1 takes on non-zero.
  function automatic logic taken(input logic j, input logic jc,
                                 input logic neq, input logic zero);
    return j | (jc & (zero ^ neq));
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Data memory: asynchronous read, synchronous write, contents not reset.
module dmem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: wait-state data-memory access, jump resolution and
// registered hand-off toward write-back.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] acOutValue,
  input  logic              zeroOut,
  input  logic [DATA_W-1:0] ulaJumpOut,
  input  logic [DATA_W-1:0] rs,
  input  logic [1:0]        rdIn,
  input  logic              WRMem,
  input  logic              WMMem,
  input  logic              RMMem,
  input  logic              NEQMem,
  input  logic              JMem,
  input  logic              JCMem,
  output logic              stall,
  output logic              jumpTaken,
  output logic [DATA_W-1:0] jumpAddr,
  output logic [DATA_W-1:0] wbData,
  output logic [1:0]        wbRd,
  output logic              wbWR
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire, stall_c, mem_op, tk, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              jump_taken_q, wb_wr_q;
  logic [DATA_W-1:0] jump_addr_q, wb_data_q;
  logic [1:0]        wb_rd_q;

  assign mem_op   = WMMem | RMMem;
  assign mem_addr = ADDR_W'(acOutValue);
  assign tk       = taken(JMem, JCMem, NEQMem, zeroOut);
  // Gate with reset so an access aborted by reset can never commit.
  assign mem_we   = reset_n & retire & WMMem;

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .clock  (clock),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(rs),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && (LATENCY != 0)) begin
          stall_c = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_W'(LATENCY - 1);
        end else begin
          retire = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      jump_taken_q <= 1'b0;
      jump_addr_q  <= '0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_wr_q      <= retire & WRMem;
      jump_taken_q <= retire & tk;
      if (retire & tk) jump_addr_q <= ulaJumpOut;
      if (retire) begin
        wb_data_q <= RMMem ? mem_rdata : acOutValue;
        wb_rd_q   <= rdIn;
      end
    end
  end

  // Stall must drop the instant reset asserts, even while inputs request memory.
  assign stall     = reset_n & stall_c;
  assign jumpTaken = jump_taken_q;
  assign jumpAddr  = jump_addr_q;
  assign wbData    = wb_data_q;
  assign wbRd      = wb_rd_q;
  assign wbWR      = wb_wr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage across three parameter sets.
module tb_mem_stage;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] acOutValue, ulaJumpOut, rs;
  logic       zeroOut;
  logic [1:0] rdIn;
  logic       WRMem, WMMem, RMMem, NEQMem, JMem, JCMem;

  logic       stall_w [3];
  logic       jt_w    [3];
  logic [7:0] ja_w    [3];
  logic [7:0] wbd_w   [3];
  logic [1:0] wbrd_w  [3];
  logic       wbwr_w  [3];

  always #5 clock = ~clock;

  mem_stage #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) u0 (
    .clock(clock), .reset_n(reset_n), .acOutValue(acOutValue), .zeroOut(zeroOut),
    .ulaJumpOut(ulaJumpOut), .rs(rs), .rdIn(rdIn), .WRMem(WRMem), .WMMem(WMMem),
    .RMMem(RMMem), .NEQMem(NEQMem), .JMem(JMem), .JCMem(JCMem),
    .stall(stall_w[0]), .jumpTaken(jt_w[0]), .jumpAddr(ja_w[0]),
    .wbData(wbd_w[0]), .wbRd(wbrd_w[0]), .wbWR(wbwr_w[0]));

  mem_stage #(.DATA_W(8), .ADDR_W(4), .LATENCY(1)) u1 (
    .clock(clock), .reset_n(reset_n), .acOutValue(acOutValue), .zeroOut(zeroOut),
    .ulaJumpOut(ulaJumpOut), .rs(rs), .rdIn(rdIn), .WRMem(WRMem), .WMMem(WMMem),
    .RMMem(RMMem), .NEQMem(NEQMem), .JMem(JMem), .JCMem(JCMem),
    .stall(stall_w[1]), .jumpTaken(jt_w[1]), .jumpAddr(ja_w[1]),
    .wbData(wbd_w[1]), .wbRd(wbrd_w[1]), .wbWR(wbwr_w[1]));

  mem_stage #(.DATA_W(8), .ADDR_W(8), .LATENCY(3)) u2 (
    .clock(clock), .reset_n(reset_n), .acOutValue(acOutValue), .zeroOut(zeroOut),
    .ulaJumpOut(ulaJumpOut), .rs(rs), .rdIn(rdIn), .WRMem(WRMem), .WMMem(WMMem),
    .RMMem(RMMem), .NEQMem(NEQMem), .JMem(JMem), .JCMem(JCMem),
    .stall(stall_w[2]), .jumpTaken(jt_w[2]), .jumpAddr(ja_w[2]),
    .wbData(wbd_w[2]), .wbRd(wbrd_w[2]), .wbWR(wbwr_w[2]));

  typedef struct {
    logic [7:0] d;
    logic [1:0] rd;
    logic       wr;
    logic       jt;
    logic [7:0] ja;
  } exp_t;

  exp_t       sb [$];
  int         lat_c [3] = '{1, 1, 3};
  int         aw_c  [3] = '{8, 4, 8};
  logic [7:0] mdl_mem [3][256];
  logic [7:0] mdl_ja  [3];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic wr, input logic wm, input logic rm, input logic neq,
                        input logic j, input logic jc, input logic zero,
                        input logic [7:0] ac, input logic [7:0] ula,
                        input logic [7:0] rsv, input logic [1:0] rd);
    WRMem = wr; WMMem = wm; RMMem = rm; NEQMem = neq; JMem = j; JCMem = jc;
    zeroOut = zero; acOutValue = ac; ulaJumpOut = ula; rs = rsv; rdIn = rd;
  endtask

  task automatic bubble();
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
  endtask

  task automatic chk_cleared(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_stall"}, stall_w[k], 0);
      chk({tag, "_jt"},    jt_w[k],    0);
      chk({tag, "_ja"},    ja_w[k],    0);
      chk({tag, "_wbd"},   wbd_w[k],   0);
      chk({tag, "_wbrd"},  wbrd_w[k],  0);
      chk({tag, "_wbwr"},  wbwr_w[k],  0);
    end
  endtask

  // Called at a falling edge: asserts reset with random inputs, checks, releases.
  task automatic do_reset();
    reset_n = 1'b0;
    set_in($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
           $urandom_range(1), $urandom_range(1), $urandom_range(1),
           8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    #1 chk_cleared("reset");
    @(negedge clock);
    bubble();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) mdl_ja[k] = 8'h00;
  endtask

  // Inputs already driven at a falling edge; checks stall/retire timing of DUT d.
  task automatic run(input int d, input logic exp_taken);
    exp_t       e;
    logic [7:0] a;
    int         n;
    a = acOutValue & 8'((1 << aw_c[d]) - 1);
    e.d  = RMMem ? mdl_mem[d][a] : acOutValue;
    e.rd = rdIn;
    e.wr = WRMem;
    e.jt = exp_taken;
    if (exp_taken) mdl_ja[d] = ulaJumpOut;
    e.ja = mdl_ja[d];
    sb.push_back(e);
    if (WMMem) mdl_mem[d][a] = rs;
    n = (WMMem || RMMem) ? lat_c[d] + 1 : 1;
    for (int i = 1; i <= n; i++) begin
      #1 chk("stall", stall_w[d], (i < n));
      @(posedge clock);
      @(negedge clock);
      if (i < n) begin
        chk("hold_wbwr", wbwr_w[d], 0);
        chk("hold_jt",   jt_w[d],   0);
      end else if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wbData",    wbd_w[d],  e.d);
        chk("wbRd",      wbrd_w[d], e.rd);
        chk("wbWR",      wbwr_w[d], e.wr);
        chk("jumpTaken", jt_w[d],   e.jt);
        chk("jumpAddr",  ja_w[d],   e.ja);
      end
    end
    $display("txn dut=%0d ac=%h wbData=%h wbRd=%0d wbWR=%0b jt=%0b ja=%h",
             d, acOutValue, wbd_w[d], wbrd_w[d], wbwr_w[d], jt_w[d], ja_w[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    bubble();
    @(negedge clock);
    // 1: reset and bubble
    do_reset();
    run(0, 0);
    // 2: store then load, LATENCY=1
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h12, 8'h00, 8'hA5, 2'd0); run(0, 0);
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00, 2'd2); run(0, 0);
    bubble(); run(0, 0);
    // 3: ALU op
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h3C, 8'h00, 8'h00, 2'd1); run(0, 0);
    // 4: jumps (target varies so a held jumpAddr is observable)
    set_in(0, 0, 0, 0, 0, 1, 1, 8'h01, 8'h40, 8'h00, 2'd0); run(0, 1);
    set_in(0, 0, 0, 0, 0, 1, 0, 8'h02, 8'h55, 8'h00, 2'd0); run(0, 0);
    set_in(0, 0, 0, 1, 0, 1, 0, 8'h03, 8'h48, 8'h00, 2'd0); run(0, 1);
    set_in(0, 0, 0, 1, 0, 1, 1, 8'h04, 8'h5A, 8'h00, 2'd0); run(0, 0);
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h05, 8'h50, 8'h00, 2'd0); run(0, 1);
    set_in(0, 0, 0, 0, 1, 0, 1, 8'h06, 8'h60, 8'h00, 2'd0); run(0, 1);
    set_in(0, 0, 0, 0, 1, 1, 0, 8'h07, 8'h70, 8'h00, 2'd0); run(0, 1);
    set_in(1, 1, 0, 0, 1, 0, 0, 8'h20, 8'h66, 8'h09, 2'd3); run(0, 1);
    bubble(); run(0, 0);
    // 5: address wrap, ADDR_W=4
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h13, 8'h00, 8'h77, 2'd0); run(1, 0);
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h00, 2'd3); run(1, 0);
    set_in(1, 1, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h11, 2'd2); run(1, 0);
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h00, 2'd1); run(1, 0);
    // 6: reset during the second ACCESS cycle, LATENCY=3
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h08, 8'h00, 8'h33, 2'd0); run(2, 0);
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h08, 8'h00, 8'h55, 2'd0);
    #1 chk("abort_stall0", stall_w[2], 1);
    @(posedge clock); @(negedge clock);
    #1 chk("abort_stall1", stall_w[2], 1);
    @(posedge clock); @(negedge clock);
    reset_n = 1'b0;
    #1 chk_cleared("midreset");
    @(negedge clock);
    bubble();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) mdl_ja[k] = 8'h00;
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h08, 8'h00, 8'h00, 2'd1); run(2, 0);
    chk("sb_empty", 8'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
